// File: rtl/irq_ctrl_if.sv
// irq_ctrl bus bundle: external lines, timer, ack/mask strobes
// and the conditioned interrupt vector towards the core.
interface irq_ctrl_if;
    logic [4:0] irq_i;
    logic       timer_int_i;
    logic       ack_we_i;
    logic [5:0] ack_i;
    logic       mask_we_i;
    logic [5:0] mask_i;
    logic [5:0] mask_o;
    logic [5:0] pending_o;
    logic [5:0] int_o;

    modport master (
        output irq_i, timer_int_i, ack_we_i, ack_i, mask_we_i, mask_i,
        input  mask_o, pending_o, int_o
    );

    modport slave (
        input  irq_i, timer_int_i, ack_we_i, ack_i, mask_we_i, mask_i,
        output mask_o, pending_o, int_o
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt front-end: sync, debounce, edge/level capture,
// W1C pending register and mask feeding the core int_i vector.
module irq_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [5:0]  EDGE_MASK       = 6'b000000
) (
    input logic       clk,
    input logic       rst,
    irq_ctrl_if.slave bus
);
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Timer is always level, so only the external bits can be edge mode.
    localparam logic [5:0] EDGE_MODE = {1'b0, EDGE_MASK[4:0]};

    logic [4:0]      s1_q, s1_d;
    logic [4:0]      s2_q, s2_d;
    logic [4:0]      filt_q, filt_d;
    logic [4:0][7:0] cnt_q, cnt_d;
    logic [5:0]      pending_q, pending_d;
    logic [5:0]      mask_q, mask_d;

    logic [5:0] ack_clr;
    logic [5:0] rise;
    logic [5:0] level;

    // Two-flop synchroniser for the asynchronous external lines.
    always_comb begin
        s1_d = bus.irq_i;
        s2_d = s1_q;
    end

    // Debounce: filtered value flips only after a run of stable samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int n = 0; n < 5; n++) begin
            if (s2_q[n] == filt_q[n]) begin
                cnt_d[n] = 8'd0;
            end else if (cnt_q[n] == CNT_LAST) begin
                filt_d[n] = s2_q[n];
                cnt_d[n]  = 8'd0;
            end else begin
                cnt_d[n] = cnt_q[n] + 8'd1;
            end
        end
    end

    // Pending: edge bits latch a filtered rise (set beats ack), level bits track.
    always_comb begin
        ack_clr   = bus.ack_we_i ? bus.ack_i : 6'd0;
        rise      = {1'b0, filt_d & ~filt_q};
        level     = {bus.timer_int_i, filt_q};
        pending_d = (EDGE_MODE & (rise | (pending_q & ~ack_clr)))
                  | (~EDGE_MODE & level);
    end

    // Mask register, independent of acknowledge.
    always_comb begin
        mask_d = bus.mask_we_i ? bus.mask_i : mask_q;
    end

    // State registers; reset drops all in-flight debounce state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            filt_q    <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            mask_q    <= 6'h3F;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            filt_q    <= filt_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    assign bus.mask_o    = mask_q;
    assign bus.pending_o = pending_q;
    assign bus.int_o     = pending_q & mask_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: reference model compared
// every cycle plus directed literal expectations.
module tb_irq_ctrl;
    localparam int         D  = 4;
    localparam logic [5:0] EM = 6'b000010;

    logic clk = 1'b0;
    logic rst = 1'b0;

    irq_ctrl_if bus ();

    irq_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .EDGE_MASK       (EM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: synchronised samples kept as a history; a line's
    // filtered value flips when the last D samples all disagree with it.
    logic [4:0] m_s1, m_s2, m_filt;
    logic [5:0] m_pend, m_mask;
    bit         hist[5][$];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_filt = '0;
        m_pend = '0; m_mask = 6'h3F;
        for (int n = 0; n < 5; n++) hist[n].delete();
    endtask

    task automatic model_step();
        logic [4:0] o_s1, o_s2, o_filt;
        logic [5:0] o_pend;
        bit         all_diff;
        o_s1 = m_s1; o_s2 = m_s2; o_filt = m_filt; o_pend = m_pend;
        for (int n = 0; n < 5; n++) begin
            hist[n].push_back(o_s2[n]);
            if (hist[n].size() > D) void'(hist[n].pop_front());
            all_diff = (hist[n].size() == D);
            foreach (hist[n][k])
                if (hist[n][k] == o_filt[n]) all_diff = 1'b0;
            if (all_diff) m_filt[n] = o_s2[n];
        end
        m_s2 = o_s1;
        m_s1 = bus.irq_i;
        for (int n = 0; n < 5; n++) begin
            if (EM[n])
                m_pend[n] = (m_filt[n] & ~o_filt[n])
                          | (o_pend[n] & ~(bus.ack_we_i & bus.ack_i[n]));
            else
                m_pend[n] = o_filt[n];
        end
        m_pend[5] = bus.timer_int_i;
        if (bus.mask_we_i) m_mask = bus.mask_i;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
            #1;
            chk("m_pending", {2'b0, bus.pending_o}, {2'b0, m_pend});
            chk("m_mask", {2'b0, bus.mask_o}, {2'b0, m_mask});
            chk("m_int", {2'b0, bus.int_o}, {2'b0, m_pend & m_mask});
        end
    end

    task automatic pedge(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Pulse line n for len sampled cycles; count cycles its pending bit
    // is high over a 16-cycle window and note the first one.
    task automatic pulse(input int n, input int len,
                         output int cnt, output int first);
        cnt = 0; first = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0)   bus.irq_i[n] = 1'b1;
            if (i == len) bus.irq_i[n] = 1'b0;
            pedge(1);
            if (bus.pending_o[n]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
    endtask

    int c, f;

    initial begin
        bus.irq_i = '0; bus.timer_int_i = 1'b0;
        bus.ack_we_i = 1'b0; bus.ack_i = '0;
        bus.mask_we_i = 1'b0; bus.mask_i = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_int", {2'b0, bus.int_o}, 8'h00);
        chk("rst_pend", {2'b0, bus.pending_o}, 8'h00);
        chk("rst_mask", {2'b0, bus.mask_o}, 8'h3F);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Level debounce on bit 2, assert then deassert
        @(negedge clk); bus.irq_i[2] = 1'b1;
        pedge(6); chk("lvl_rise_e5", {2'b0, bus.int_o}, 8'h00);
        pedge(1); chk("lvl_rise_e6", {2'b0, bus.int_o}, 8'h04);
        @(negedge clk); bus.irq_i[2] = 1'b0;
        pedge(6); chk("lvl_fall_e5", {2'b0, bus.int_o}, 8'h04);
        pedge(1); chk("lvl_fall_e6", {2'b0, bus.int_o}, 8'h00);

        // Glitch rejection and minimum pulse on level bit 0
        pulse(0, 3, c, f);
        chk("glitch3_cnt", 8'(c), 8'd0);
        pulse(0, 4, c, f);
        chk("pulse4_cnt", 8'(c), 8'd4);
        chk("pulse4_first", 8'(f), 8'd6);

        // Edge capture on bit 1 holds after the line drops
        pulse(1, 8, c, f);
        chk("edge_cnt", 8'(c), 8'd11);
        chk("edge_first", 8'(f), 8'd5);
        chk("edge_hold", {2'b0, bus.pending_o}, 8'h02);
        @(negedge clk); bus.ack_we_i = 1'b1; bus.ack_i = 6'h02;
        pedge(1); chk("edge_ack", {2'b0, bus.pending_o}, 8'h00);
        @(negedge clk); bus.ack_we_i = 1'b0; bus.ack_i = '0;

        // Set beats clear when the filtered rise meets the ack edge
        bus.irq_i[1] = 1'b1;
        pedge(5);
        @(negedge clk); bus.ack_we_i = 1'b1; bus.ack_i = 6'h02;
        pedge(1); chk("set_wins", {2'b0, bus.pending_o}, 8'h02);
        @(negedge clk); bus.ack_we_i = 1'b0;
        // Ack and mask write on the same edge
        @(negedge clk);
        bus.ack_we_i = 1'b1; bus.mask_we_i = 1'b1; bus.mask_i = 6'h3D;
        pedge(1);
        chk("ackmask_pend", {2'b0, bus.pending_o}, 8'h00);
        chk("ackmask_mask", {2'b0, bus.mask_o}, 8'h3D);
        @(negedge clk);
        bus.ack_we_i = 1'b0; bus.ack_i = '0; bus.mask_we_i = 1'b0;
        bus.irq_i[1] = 1'b0;
        repeat (8) @(negedge clk);

        // Mask and timer
        bus.mask_we_i = 1'b1; bus.mask_i = 6'h1F;
        pedge(1); chk("mask_1f", {2'b0, bus.mask_o}, 8'h1F);
        @(negedge clk); bus.mask_we_i = 1'b0; bus.timer_int_i = 1'b1;
        pedge(1);
        chk("tmr_pend", {2'b0, bus.pending_o}, 8'h20);
        chk("tmr_masked", {2'b0, bus.int_o}, 8'h00);
        @(negedge clk); bus.mask_we_i = 1'b1; bus.mask_i = 6'h3F;
        pedge(1); chk("tmr_unmask", {2'b0, bus.int_o}, 8'h20);
        @(negedge clk); bus.mask_we_i = 1'b0;

        // Async reset mid-debounce of level bit 3
        bus.mask_we_i = 1'b1; bus.mask_i = 6'h2B; bus.irq_i[3] = 1'b1;
        pedge(1);
        @(negedge clk); bus.mask_we_i = 1'b0;
        pedge(2);
        chk("pre_rst_int", {2'b0, bus.int_o}, 8'h20);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("mid_rst_int", {2'b0, bus.int_o}, 8'h00);
        chk("mid_rst_pend", {2'b0, bus.pending_o}, 8'h00);
        chk("mid_rst_mask", {2'b0, bus.mask_o}, 8'h3F);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pedge(6); chk("rerun_e5", {2'b0, bus.pending_o}, 8'h20);
        pedge(1); chk("rerun_e6", {2'b0, bus.pending_o}, 8'h28);

        // Timer falls with one cycle latency
        @(negedge clk); bus.timer_int_i = 1'b0; bus.irq_i = '0;
        pedge(1); chk("tmr_fall", {7'b0, bus.int_o[5]}, 8'h00);
        pedge(8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
